// File: rtl/sar_seq_pkg.sv
// Shared definitions for the SAR conversion sequencer: state encoding,
// default timing parameters, data width and result saturation helper.
package sar_seq_pkg;

   localparam int unsigned DATA_W            = 12;
   localparam int unsigned DEF_SAMPLE_CYCLES = 4;
   localparam int unsigned DEF_AUTO_GAP      = 16;

   localparam logic [DATA_W-1:0] MSB_CODE = 12'h800;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SAMPLE,
      ST_CONVERT,
      ST_DONE,
      ST_GAP
   } sar_state_t;

   function automatic logic [DATA_W-1:0] sat_sub(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
      return (a >= b) ? (a - b) : '0;
   endfunction

endpackage

// File: rtl/sar_step_tick.sv
// SAR step-rate enable: every cycle, or every second cycle when i_half is set.
// The phase restarts on each entry so the first half-rate tick lands on cycle 2.
module sar_step_tick (
   input  logic clk,
   input  logic reset,
   input  logic i_en,
   input  logic i_half,
   output logic o_tick
);

   logic r_phase;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_phase <= 1'b0;
      end else if (!i_en) begin
         r_phase <= 1'b0;
      end else begin
         r_phase <= ~r_phase;
      end
   end

   assign o_tick = i_en & (~i_half | r_phase);

endmodule

// File: rtl/sar_conv_sequencer.sv
// SAR ADC conversion/calibration sequencer: track/hold, 12-bit successive
// approximation, offset-corrected result, optional continuous conversion.
module sar_conv_sequencer
   import sar_seq_pkg::*;
#(
   parameter int unsigned SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
   parameter int unsigned AUTO_GAP      = DEF_AUTO_GAP
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              adc_en_i,
   input  logic              start_conv_i,
   input  logic              auto_mode_i,
   input  logic              int_en_i,
   input  logic              start_cal_i,
   input  logic              clk_sel_i,
   input  logic              vref_rdy_i,
   input  logic              cmp_i,
   output logic              sample_o,
   output logic              cal_short_o,
   output logic [DATA_W-1:0] dac_code_o,
   output logic [DATA_W-1:0] adc_data_o,
   output logic [DATA_W-1:0] cal_offset_o,
   output logic              eoc_o,
   output logic              busy_o,
   output logic              irq_o
);

   localparam logic [7:0] SAMPLE_LAST = 8'(SAMPLE_CYCLES - 1);
   localparam logic [7:0] GAP_LAST    = 8'(AUTO_GAP);

   sar_state_t        r_state;
   logic              r_start_q;
   logic              r_cal_q;
   logic              r_armed;
   logic              r_is_cal;
   logic              r_sel;
   logic [7:0]        r_cnt;
   logic [3:0]        r_idx;
   logic [DATA_W-1:0] r_code;
   logic [DATA_W-1:0] r_dac;
   logic [DATA_W-1:0] r_data;
   logic [DATA_W-1:0] r_cal_off;
   logic              r_busy;
   logic              r_sample;
   logic              r_cal_short;
   logic              r_eoc;
   logic              r_irq;

   logic              w_ok;
   logic              w_conv_edge;
   logic              w_cal_edge;
   logic              w_converting;
   logic              w_tick;
   logic [DATA_W-1:0] w_next_code;

   assign w_ok         = adc_en_i & vref_rdy_i;
   assign w_conv_edge  = start_conv_i & ~r_start_q;
   assign w_cal_edge   = start_cal_i & ~r_cal_q;
   assign w_converting = (r_state == ST_CONVERT);

   sar_step_tick u_step_tick (
      .clk    (clk),
      .reset  (reset),
      .i_en   (w_converting),
      .i_half (r_sel),
      .o_tick (w_tick)
   );

   always_comb begin
      w_next_code = r_code;
      if (!cmp_i) w_next_code[r_idx] = 1'b0;
      if (r_idx != 4'd0) w_next_code[r_idx - 4'd1] = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_start_q   <= 1'b0;
         r_cal_q     <= 1'b0;
         r_armed     <= 1'b0;
         r_is_cal    <= 1'b0;
         r_sel       <= 1'b0;
         r_cnt       <= '0;
         r_idx       <= '0;
         r_code      <= '0;
         r_dac       <= '0;
         r_data      <= '0;
         r_cal_off   <= '0;
         r_busy      <= 1'b0;
         r_sample    <= 1'b0;
         r_cal_short <= 1'b0;
         r_eoc       <= 1'b0;
         r_irq       <= 1'b0;
      end else begin
         r_start_q <= start_conv_i;
         r_cal_q   <= start_cal_i;
         // Edge-detect history is zero after reset, so the first cycle is
         // masked to keep a level already high at release from triggering.
         r_armed   <= 1'b1;
         r_irq     <= 1'b0;
         if ((r_state != ST_IDLE) && !w_ok) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_sample    <= 1'b0;
            r_cal_short <= 1'b0;
            r_dac       <= '0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (r_armed && w_ok && (w_cal_edge || w_conv_edge)) begin
                     r_state     <= ST_SAMPLE;
                     r_busy      <= 1'b1;
                     r_sample    <= 1'b1;
                     r_is_cal    <= w_cal_edge;
                     r_cal_short <= w_cal_edge;
                     r_sel       <= clk_sel_i;
                     r_cnt       <= '0;
                     if (!w_cal_edge) r_eoc <= 1'b0;
                  end
               end
               ST_SAMPLE: begin
                  if (r_cnt == SAMPLE_LAST) begin
                     r_state  <= ST_CONVERT;
                     r_sample <= 1'b0;
                     r_code   <= MSB_CODE;
                     r_dac    <= MSB_CODE;
                     r_idx    <= 4'd11;
                  end else begin
                     r_cnt <= r_cnt + 8'd1;
                  end
               end
               ST_CONVERT: begin
                  if (w_tick) begin
                     r_code <= w_next_code;
                     if (r_idx == 4'd0) begin
                        r_state     <= ST_DONE;
                        r_dac       <= '0;
                        r_cal_short <= 1'b0;
                     end else begin
                        r_dac <= w_next_code;
                        r_idx <= r_idx - 4'd1;
                     end
                  end
               end
               ST_DONE: begin
                  if (r_is_cal) begin
                     r_cal_off <= r_code;
                  end else begin
                     r_data <= sat_sub(r_code, r_cal_off);
                     r_eoc  <= 1'b1;
                     r_irq  <= int_en_i;
                  end
                  if (!r_is_cal && auto_mode_i) begin
                     r_state <= ST_GAP;
                     r_cnt   <= '0;
                  end else begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end
               end
               ST_GAP: begin
                  if (!auto_mode_i) begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end else if (r_cnt == GAP_LAST) begin
                     r_state  <= ST_SAMPLE;
                     r_sample <= 1'b1;
                     r_is_cal <= 1'b0;
                     r_sel    <= clk_sel_i;
                     r_cnt    <= '0;
                  end else begin
                     r_cnt <= r_cnt + 8'd1;
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign sample_o     = r_sample;
   assign cal_short_o  = r_cal_short;
   assign dac_code_o   = r_dac;
   assign adc_data_o   = r_data;
   assign cal_offset_o = r_cal_off;
   assign eoc_o        = r_eoc;
   assign busy_o       = r_busy;
   assign irq_o        = r_irq;

endmodule

// File: tb/tb_sar_conv_sequencer.sv
// Bench for sar_conv_sequencer: ideal comparator, timeline reference model
// checked every cycle, plus directed literal expectations.
module tb_sar_conv_sequencer;

   localparam int S = 4;
   localparam int G = 16;

   logic        clk;
   logic        rst;
   logic        adc_en_i, start_conv_i, auto_mode_i, int_en_i;
   logic        start_cal_i, clk_sel_i, vref_rdy_i, cmp_i;
   logic        sample_o, cal_short_o, eoc_o, busy_o, irq_o;
   logic [11:0] dac_code_o, adc_data_o, cal_offset_o;
   logic [11:0] vin;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   sar_conv_sequencer #(.SAMPLE_CYCLES(S), .AUTO_GAP(G)) dut (
      .clk          (clk),
      .reset        (rst),
      .adc_en_i     (adc_en_i),
      .start_conv_i (start_conv_i),
      .auto_mode_i  (auto_mode_i),
      .int_en_i     (int_en_i),
      .start_cal_i  (start_cal_i),
      .clk_sel_i    (clk_sel_i),
      .vref_rdy_i   (vref_rdy_i),
      .cmp_i        (cmp_i),
      .sample_o     (sample_o),
      .cal_short_o  (cal_short_o),
      .dac_code_o   (dac_code_o),
      .adc_data_o   (adc_data_o),
      .cal_offset_o (cal_offset_o),
      .eoc_o        (eoc_o),
      .busy_o       (busy_o),
      .irq_o        (irq_o)
   );

   // Ideal comparator: input voltage expressed as a code.
   assign cmp_i = (vin >= dac_code_o);

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 40)
            $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // m_t = cycles since sampling began (-1 when idle); phases follow from it.
   int          m_t = -1;
   bit          m_cal, m_sel, m_eoc, m_irq, m_ps, m_pc, m_armed, m_ce, m_ke;
   logic [11:0] m_data, m_off;
   int          m_d;

   function automatic int conv_len(input bit sel);
      return sel ? 24 : 12;
   endfunction

   function automatic logic [11:0] trial(input int j, input logic [11:0] v);
      logic [11:0] hi;
      hi = 12'hFFF << (12 - j);
      return (v & hi) | (12'h001 << (11 - j));
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_t = -1; m_cal = 0; m_sel = 0; m_eoc = 0; m_irq = 0;
         m_ps = 0; m_pc = 0; m_armed = 0; m_data = '0; m_off = '0;
      end else begin
         m_ce = start_conv_i && !m_ps;
         m_ke = start_cal_i && !m_pc;
         m_ps = start_conv_i;
         m_pc = start_cal_i;
         m_irq = 0;
         m_d = S + conv_len(m_sel);
         if (m_t >= 0 && !(adc_en_i && vref_rdy_i)) begin
            m_t = -1;
         end else if (m_t < 0) begin
            if (m_armed && adc_en_i && vref_rdy_i && (m_ce || m_ke)) begin
               m_t = 0; m_cal = m_ke; m_sel = clk_sel_i;
               if (!m_ke) m_eoc = 0;
            end
         end else if (m_t == m_d) begin
            if (m_cal) m_off = vin;
            else begin
               m_data = (vin > m_off) ? vin - m_off : 12'h000;
               m_eoc = 1; m_irq = int_en_i;
            end
            m_t = (!m_cal && auto_mode_i) ? m_d + 1 : -1;
         end else if (m_t > m_d) begin
            if (!auto_mode_i) m_t = -1;
            else if (m_t == m_d + 1 + G) begin m_t = 0; m_cal = 0; m_sel = clk_sel_i; end
            else m_t++;
         end else begin
            m_t++;
         end
         m_armed = 1;
      end
   end

   always @(negedge clk) begin
      int  cl;
      bit  in_conv;
      logic [11:0] e_dac;
      cl = conv_len(m_sel);
      in_conv = (m_t >= S) && (m_t < S + cl);
      e_dac = in_conv ? trial((m_t - S) / (m_sel ? 2 : 1), vin) : 12'h000;
      chk("model_busy",   busy_o,      (m_t >= 0));
      chk("model_sample", sample_o,    (m_t >= 0 && m_t < S));
      chk("model_short",  cal_short_o, (m_cal && m_t >= 0 && m_t < S + cl));
      chk("model_dac",    dac_code_o,  e_dac);
      chk("model_data",   adc_data_o,  m_data);
      chk("model_offset", cal_offset_o, m_off);
      chk("model_eoc",    eoc_o,       m_eoc);
      chk("model_irq",    irq_o,       m_irq);
   end

   // ---------------- directed stimulus ----------------
   task automatic goto(input int target);
      do @(negedge clk); while (cyc < target);
   endtask

   task automatic next_drive();
      @(posedge clk); #2;
   endtask

   task automatic wait_irq(input string name, input int limit, output int c);
      c = -1000;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (irq_o === 1'b1) begin c = cyc; break; end
      end
      if (c < 0) begin
         checks++; failures++;
         $display("FAIL %s: no irq_o within %0d cycles, required a pulse", name, limit);
      end
   endtask

   int n, c1, c2, c3;

   initial begin
      rst = 1; adc_en_i = 0; start_conv_i = 0; auto_mode_i = 0; int_en_i = 0;
      start_cal_i = 0; clk_sel_i = 0; vref_rdy_i = 0; vin = '0;
      repeat (3) @(posedge clk); #2;
      chk("reset_busy", busy_o, 0);
      chk("reset_data", adc_data_o, 12'h000);
      chk("reset_dac",  dac_code_o, 12'h000);

      // level already high at reset release must not trigger
      adc_en_i = 1; vref_rdy_i = 1; start_conv_i = 1;
      rst = 0;
      goto(cyc + 3);
      chk("no_trigger_at_release", busy_o, 0);
      next_drive(); start_conv_i = 0;

      // plain conversion, latency and SAR trial codes
      vin = 12'hA5C; int_en_i = 1;
      next_drive(); start_conv_i = 1; n = cyc;
      goto(n);      chk("lat_busy_N", busy_o, 0);
      goto(n + 1);  chk("lat_busy_N1", busy_o, 1); chk("lat_sample_N1", sample_o, 1);
      goto(n + 5);  chk("dac_800", dac_code_o, 12'h800);
      goto(n + 6);  chk("dac_C00", dac_code_o, 12'hC00);
      goto(n + 7);  chk("dac_A00", dac_code_o, 12'hA00);
      goto(n + 17); chk("done_busy", busy_o, 1); chk("done_dac", dac_code_o, 12'h000);
      goto(n + 18); chk("res_busy", busy_o, 0); chk("res_data", adc_data_o, 12'hA5C);
                    chk("res_eoc", eoc_o, 1); chk("res_irq", irq_o, 1);
      goto(n + 19); chk("irq_one_cycle", irq_o, 0);
      next_drive(); start_conv_i = 0;

      // calibration then offset-corrected conversion
      next_drive(); vin = 12'h010; start_cal_i = 1; n = cyc;
      goto(n + 1);  chk("cal_short_sample", cal_short_o, 1);
      goto(n + 10); chk("cal_short_conv", cal_short_o, 1);
      goto(n + 18); chk("cal_offset", cal_offset_o, 12'h010); chk("cal_no_irq", irq_o, 0);
                    chk("cal_data_kept", adc_data_o, 12'hA5C);
      next_drive(); start_cal_i = 0; vin = 12'hA5C;
      next_drive(); start_conv_i = 1; n = cyc;
      goto(n + 18); chk("corrected_data", adc_data_o, 12'hA4C); chk("corrected_irq", irq_o, 1);
      next_drive(); start_conv_i = 0;

      // saturation
      next_drive(); vin = 12'h020; start_cal_i = 1; n = cyc;
      goto(n + 18); chk("cal_offset_20", cal_offset_o, 12'h020);
      next_drive(); start_cal_i = 0; vin = 12'h005;
      next_drive(); start_conv_i = 1; n = cyc;
      goto(n + 18); chk("saturated_data", adc_data_o, 12'h000); chk("saturated_eoc", eoc_o, 1);
      next_drive(); start_conv_i = 0;

      // simultaneous edges: cal wins; conv edge while busy dropped
      next_drive(); vin = 12'h030; start_conv_i = 1; start_cal_i = 1; n = cyc;
      goto(n + 1);  chk("both_is_cal", cal_short_o, 1);
      next_drive(); start_conv_i = 0;
      next_drive(); start_conv_i = 1;
      goto(n + 18); chk("both_busy_done", busy_o, 0); chk("both_offset", cal_offset_o, 12'h030);
                    chk("both_data_kept", adc_data_o, 12'h000);
      goto(n + 20); chk("busy_edge_dropped", busy_o, 0);
      next_drive(); start_conv_i = 0; start_cal_i = 0;

      // adc_en_i dropped at convert tick 5
      next_drive(); vin = 12'h7FF; start_conv_i = 1; n = cyc;
      goto(n + 8);
      next_drive(); adc_en_i = 0;
      goto(n + 10); chk("abort_busy", busy_o, 0); chk("abort_dac", dac_code_o, 12'h000);
                    chk("abort_data", adc_data_o, 12'h000); chk("abort_irq", irq_o, 0);
      next_drive(); adc_en_i = 1;
      next_drive(); start_conv_i = 0;

      // reset mid-SAMPLE
      next_drive(); start_conv_i = 1; n = cyc;
      goto(n + 2);  chk("pre_reset_sample", sample_o, 1);
      next_drive(); rst = 1;
      goto(n + 3);  chk("rst_sample", sample_o, 0); chk("rst_busy", busy_o, 0);
                    chk("rst_offset", cal_offset_o, 12'h000);
      next_drive(); rst = 0;
      goto(cyc + 3); chk("rst_no_retrigger", busy_o, 0);
      next_drive(); start_conv_i = 0;

      // auto mode, half-rate stepping: irq spacing
      next_drive(); vin = 12'h3C3; auto_mode_i = 1; clk_sel_i = 1; int_en_i = 1;
      next_drive(); start_conv_i = 1; n = cyc;
      wait_irq("auto_irq1", 60, c1);
      chk("auto_first_latency", c1 - n, 30);
      chk("auto_data", adc_data_o, 12'h3C3);
      next_drive(); start_conv_i = 0;
      wait_irq("auto_irq2", 80, c2);
      chk("auto_spacing", c2 - c1, 46);
      goto(c2 + 20);
      next_drive(); auto_mode_i = 0;
      wait_irq("auto_irq3", 80, c3);
      chk("auto_last_spacing", c3 - c2, 46);
      chk("auto_stopped_busy", busy_o, 0);
      goto(c3 + 60);
      chk("auto_stays_idle", busy_o, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
